cpu_boot_loader: RTL and testbench
==================================

# cpu_boot_loader

Byte-stream program loader that sits directly upstream of the `cpu` top. It receives load frames over a valid/ready byte interface, drives the CPU's external instruction-memory and data-memory write ports word by word, and raises the CPU `enable` only after a start command. Until then the CPU stays quiescent. A halt command returns control to the loader.

## Interface
Parameters:
- IMEM_WORDS, 128: instruction-memory capacity in 32-bit words (512 B).
- DMEM_WORDS, 128: data-memory capacity in 64-bit words (1024 B).

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- arst  in  1  asynchronous, active-high reset.
- in_valid  in  1  byte-stream valid.
- in_data  in  8  byte-stream payload.
- in_ready  out  1  loader accepts byte this cycle; transfer = in_valid & in_ready.
- addr_ext  out  64  instruction-memory byte address.
- wen_ext  out  1  instruction-memory write strobe, one-cycle pulse per word.
- ren_ext  out  1  constant 0.
- wdata_ext  out  32  instruction word.
- addr_ext_2  out  64  data-memory byte address.
- wen_ext_2  out  1  data-memory write strobe, one-cycle pulse per word.
- ren_ext_2  out  1  constant 0.
- wdata_ext_2  out  64  data word.
- cpu_enable  out  1  drives cpu `enable`.
- busy  out  1  high in any state other than IDLE and RUN.
- error  out  1  sticky protocol error.

## Operation
- Frame format:
  - Command byte first.
  - 0x49 ('I'): load instruction memory.
  - 0x44 ('D'): load data memory.
  - 0x47 ('G'): go.
  - 0x48 ('H'): halt; honoured only in RUN.
- Load frames continue with a 16-bit word count N, low byte first. Then N words follow, each little-endian: 4 bytes for I, 8 bytes for D.
- Word k of a load frame is written at byte address 4k (I) or 8k (D). Every load restarts at address 0.
- States: IDLE, CNT_LO, CNT_HI, DATA, WRITE, RUN, ERR.
- IDLE:
  - 'I' or 'D' → CNT_LO, latching the target.
  - 'G' → RUN.
  - 'H' is ignored.
  - Any other byte → ERR.
- CNT_LO → CNT_HI on the next accepted byte.
- CNT_HI:
  - N = 0 → IDLE.
  - N > IMEM_WORDS (I) or N > DMEM_WORDS (D) → ERR. No write occurs.
  - Otherwise → DATA.
- DATA: shift bytes into the assembly register at positions 0..3 (I) or 0..7 (D). Accepting the final byte of a word → WRITE.
- WRITE (exactly one cycle):
  - Strobe of the selected target = 1, with its address and wdata valid.
  - Word counter increments.
  - If counter == N → IDLE, else → DATA.
- RUN: cpu_enable = 1. 'H' → IDLE, and cpu_enable falls at that edge. Every other byte is accepted and discarded.
- ERR: error = 1, in_ready = 0, cpu_enable = 0. Only arst leaves ERR.
- in_ready is 1 in IDLE, CNT_LO, CNT_HI, DATA and RUN; it is 0 in WRITE and ERR.
- Strobe and bus rules:
  - Only one strobe fires per WRITE; the other target's strobe stays 0.
  - Address and wdata buses hold their last written value outside WRITE.
- Word counter is 16 bits. Address = counter shifted left by 2 (I) or 3 (D), zero-extended to 64 bits.

## Timing
- Reset values (asserted asynchronously):
  - State = IDLE.
  - All outputs 0 except in_ready = 1.
  - Address, data and assembly registers = 0; counter = 0.
- Byte accepted at edge t with in_valid & in_ready: the state update is visible after t.
- Write latency: the last byte of a word is accepted at edge t. The strobe is high for the cycle between edges t and t+1, and the memory captures at edge t+1.
- Maximum throughput: one word per 5 cycles (I) or 9 cycles (D).
- in_valid held high while in_ready = 0: the byte is not consumed and must be presented again. The loader does not depend on in_data being stable while in_ready = 0.
- Reset mid-frame or mid-WRITE: immediately aborts and clears all state. Any in-flight strobe drops asynchronously. Partially loaded memory content is left as is.
- 'G' accepted at edge t: cpu_enable = 1 from t onward.

## Test plan
- Reset, then stream 0x49, 0x02, 0x00, 13 00 00 00, 93 00 10 00 → wen_ext pulses twice, with addr 0 / 0x00000013 and addr 4 / 0x00100093. wen_ext_2 never fires. busy returns to 0.
- Stream 0x44, 0x01, 0x00, 88 77 66 55 44 33 22 11 → single wen_ext_2 at addr_ext_2 = 0, wdata_ext_2 = 0x1122334455667788.
- Stream 0x47, then 0x00 and 0x48 → cpu_enable = 1 from the edge accepting 0x47 until the edge accepting 0x48. The 0x00 byte is discarded.
- Stream 0x49, 0x81, 0x00 (N = 129 > IMEM_WORDS) → ERR: error = 1, in_ready = 0, no strobe. arst returns to IDLE with error = 0.
- Stream unknown command 0x55 in IDLE → ERR. Separately, stream 0x49, 0x00, 0x00 → IDLE with no write.
- Toggle in_valid randomly through an I load of 3 words, then assert arst during the 2nd word → strobes only at addr 0 (and 4 if already reached). After reset, outputs are 0 and in_ready = 1.

Source files
------------

// File: rtl/cpu_boot_loader.sv
// Byte-stream program loader: parses I/D load frames into CPU instruction/data
// memory writes, and gates the CPU enable with G (go) / H (halt) commands.
module cpu_boot_loader #(
  parameter int IMEM_WORDS = 128,
  parameter int DMEM_WORDS = 128
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [63:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  output logic [63:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic        ren_ext_2,
  output logic [63:0] wdata_ext_2,
  output logic        cpu_enable,
  output logic        busy,
  output logic        error
);

  typedef enum logic [2:0] {IDLE, CNT_LO, CNT_HI, DATA, WRITE, RUN, ERR} state_t;

  localparam logic [15:0] IMEM_N = 16'(IMEM_WORDS);
  localparam logic [15:0] DMEM_N = 16'(DMEM_WORDS);

  state_t      state, state_nxt;
  logic        tgt_d;
  logic [7:0]  cnt_lo;
  logic [15:0] n_words, word_cnt;
  logic [2:0]  byte_idx;
  logic [63:0] asm_word, asm_next;
  logic        xfer, last_byte;
  logic [15:0] n_rx, lim, word_cnt_inc;

  assign in_ready     = (state != WRITE) && (state != ERR);
  assign xfer         = in_valid & in_ready;
  assign n_rx         = {in_data, cnt_lo};
  assign lim          = tgt_d ? DMEM_N : IMEM_N;
  assign last_byte    = byte_idx == (tgt_d ? 3'd7 : 3'd3);
  assign word_cnt_inc = word_cnt + 16'd1;
  assign ren_ext      = 1'b0;
  assign ren_ext_2    = 1'b0;

  always_comb begin
    asm_next = asm_word;
    asm_next[{byte_idx, 3'b000} +: 8] = in_data;
  end

  always_comb begin
    state_nxt  = state;
    cpu_enable = 1'b0;
    busy       = 1'b1;
    error      = 1'b0;
    wen_ext    = 1'b0;
    wen_ext_2  = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (xfer) begin
          case (in_data)
            8'h49, 8'h44: state_nxt = CNT_LO;
            8'h47:        state_nxt = RUN;
            8'h48:        state_nxt = IDLE;
            default:      state_nxt = ERR;
          endcase
        end
      end
      CNT_LO: if (xfer) state_nxt = CNT_HI;
      CNT_HI: begin
        if (xfer) begin
          if (n_rx == 16'd0)   state_nxt = IDLE;
          else if (n_rx > lim) state_nxt = ERR;
          else                 state_nxt = DATA;
        end
      end
      DATA: if (xfer && last_byte) state_nxt = WRITE;
      WRITE: begin
        wen_ext   = ~tgt_d;
        wen_ext_2 = tgt_d;
        state_nxt = (word_cnt_inc == n_words) ? IDLE : DATA;
      end
      RUN: begin
        busy       = 1'b0;
        cpu_enable = 1'b1;
        if (xfer && in_data == 8'h48) state_nxt = IDLE;
      end
      ERR: error = 1'b1;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state       <= IDLE;
      tgt_d       <= 1'b0;
      cnt_lo      <= 8'd0;
      n_words     <= 16'd0;
      word_cnt    <= 16'd0;
      byte_idx    <= 3'd0;
      asm_word    <= 64'd0;
      addr_ext    <= 64'd0;
      wdata_ext   <= 32'd0;
      addr_ext_2  <= 64'd0;
      wdata_ext_2 <= 64'd0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (xfer && (in_data == 8'h49 || in_data == 8'h44)) tgt_d <= (in_data == 8'h44);
        CNT_LO: if (xfer) cnt_lo <= in_data;
        CNT_HI: begin
          if (xfer) begin
            n_words  <= n_rx;
            word_cnt <= 16'd0;
            byte_idx <= 3'd0;
          end
        end
        DATA: begin
          if (xfer) begin
            asm_word <= asm_next;
            byte_idx <= byte_idx + 3'd1;
            // Buses are loaded here so they are valid throughout the WRITE cycle
            if (last_byte) begin
              byte_idx <= 3'd0;
              if (tgt_d) begin
                addr_ext_2  <= {45'd0, word_cnt, 3'b000};
                wdata_ext_2 <= asm_next;
              end else begin
                addr_ext  <= {46'd0, word_cnt, 2'b00};
                wdata_ext <= asm_next[31:0];
              end
            end
          end
        end
        WRITE: word_cnt <= word_cnt_inc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_boot_loader.sv
// Bench for cpu_boot_loader: frame-level reference model compared every cycle,
// directed frames with literal expectations, and randomized frame streams.
module tb_cpu_boot_loader;
  localparam int IW = 128;
  localparam int DW = 128;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready, wen_ext, ren_ext, wen_ext_2, ren_ext_2, cpu_enable, busy, error;
  logic [63:0] addr_ext, addr_ext_2, wdata_ext_2;
  logic [31:0] wdata_ext;

  always #5 clk = ~clk;

  cpu_boot_loader #(.IMEM_WORDS(IW), .DMEM_WORDS(DW)) dut (
    .clk(clk), .arst(arst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
    .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
    .wdata_ext_2(wdata_ext_2), .cpu_enable(cpu_enable), .busy(busy), .error(error)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame-level view of the byte stream
  bit          m_err, m_run, m_tgt_d, m_wpend;
  int          m_hdr, m_total, m_done, m_bytes;
  logic [7:0]  m_nlo;
  logic [7:0]  m_asm [8];
  logic [63:0] m_ai, m_di, m_ad, m_dd;
  bit          v_s;
  logic [7:0]  d_s;

  function automatic bit m_ready();
    return !m_err && !m_wpend;
  endfunction

  function automatic bit m_busy();
    return m_err || m_hdr != 0 || m_done < m_total || m_wpend;
  endfunction

  task automatic m_reset();
    m_err = 0; m_run = 0; m_tgt_d = 0; m_wpend = 0;
    m_hdr = 0; m_total = 0; m_done = 0; m_bytes = 0; m_nlo = 8'd0;
    m_ai = 64'd0; m_di = 64'd0; m_ad = 64'd0; m_dd = 64'd0;
  endtask

  task automatic m_byte(input logic [7:0] b);
    int n, sz;
    logic [63:0] word;
    if (m_run) begin
      if (b == 8'h48) m_run = 0;
    end else if (m_hdr == 1) begin
      m_nlo = b; m_hdr = 2;
    end else if (m_hdr == 2) begin
      n = int'({b, m_nlo});
      m_hdr = 0;
      if (n > (m_tgt_d ? DW : IW)) m_err = 1;
      else begin m_total = n; m_done = 0; m_bytes = 0; end
    end else if (m_done < m_total) begin
      sz = m_tgt_d ? 8 : 4;
      m_asm[m_bytes] = b;
      m_bytes++;
      if (m_bytes == sz) begin
        word = 64'd0;
        for (int i = 0; i < sz; i++) word |= 64'(m_asm[i]) << (8 * i);
        if (m_tgt_d) begin m_ad = 64'(m_done * 8); m_dd = word; end
        else begin m_ai = 64'(m_done * 4); m_di = word; end
        m_done++; m_bytes = 0; m_wpend = 1;
      end
    end else begin
      case (b)
        8'h49: begin m_tgt_d = 0; m_hdr = 1; m_total = 0; m_done = 0; end
        8'h44: begin m_tgt_d = 1; m_hdr = 1; m_total = 0; m_done = 0; end
        8'h47: m_run = 1;
        8'h48: ;
        default: m_err = 1;
      endcase
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge arst);
      if (arst) m_reset();
      else if (m_wpend) m_wpend = 0;
      else if (v_s && m_ready()) m_byte(d_s);
    end
  end

  logic [63:0] cap_i[$];
  logic [63:0] cap_da[$];
  logic [63:0] cap_dd[$];

  initial begin
    forever begin
      @(negedge clk);
      chk("in_ready", 64'(in_ready), 64'(m_ready()));
      chk("busy", 64'(busy), 64'(m_busy()));
      chk("cpu_enable", 64'(cpu_enable), 64'(m_run));
      chk("error", 64'(error), 64'(m_err));
      chk("wen_ext", 64'(wen_ext), 64'(m_wpend && !m_tgt_d));
      chk("wen_ext_2", 64'(wen_ext_2), 64'(m_wpend && m_tgt_d));
      chk("ren", 64'({ren_ext, ren_ext_2}), 64'd0);
      chk("addr_ext", addr_ext, m_ai);
      chk("wdata_ext", 64'(wdata_ext), m_di);
      chk("addr_ext_2", addr_ext_2, m_ad);
      chk("wdata_ext_2", wdata_ext_2, m_dd);
      if (wen_ext === 1'b1) cap_i.push_back({addr_ext[31:0], wdata_ext});
      if (wen_ext_2 === 1'b1) begin cap_da.push_back(addr_ext_2); cap_dd.push_back(wdata_ext_2); end
      v_s = in_valid;
      d_s = in_data;
    end
  end

  logic [7:0] bq[$];

  task automatic send(input logic [7:0] b, input int gap);
    bit ok;
    int k;
    while ($urandom_range(99) < gap) begin
      in_valid = 1'b0; in_data = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1; in_data = b; k = 0;
    do begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1; k++;
    end while (!ok && k < 64);
    in_valid = 1'b0;
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL handshake: byte %0h not accepted, in_ready %0b expected 1", b, in_ready);
    end
  endtask

  task automatic send_bq(input int gap);
    while (bq.size() > 0) send(bq.pop_front(), gap);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    in_valid = 1'b0;
    #2 arst = 1'b1;
    @(posedge clk); #1 arst = 1'b0;
    cap_i.delete(); cap_da.delete(); cap_dd.delete();
  endtask

  task automatic push_frame(input logic [7:0] cmd, input int n, input int sz);
    bq.push_back(cmd); bq.push_back(8'(n)); bq.push_back(8'(n >> 8));
    for (int i = 0; i < n * sz; i++) bq.push_back(8'($urandom));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 arst = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cpu_enable", 64'(cpu_enable), 64'd0);
    chk("rst_addr_ext", addr_ext, 64'd0);

    bq = '{8'h49, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    send_bq(0); idle(3);
    chk("i_count", 64'(cap_i.size()), 64'd2);
    if (cap_i.size() == 2) begin
      chk("i_word0", cap_i[0], {32'h0, 32'h0000_0013});
      chk("i_word1", cap_i[1], {32'h4, 32'h0010_0093});
    end
    chk("i_no_d", 64'(cap_da.size()), 64'd0);
    chk("i_busy_done", 64'(busy), 64'd0);

    bq = '{8'h44, 8'h01, 8'h00, 8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
    send_bq(0); idle(3);
    chk("d_count", 64'(cap_da.size()), 64'd1);
    if (cap_da.size() == 1) begin
      chk("d_addr", cap_da[0], 64'd0);
      chk("d_data", cap_dd[0], 64'h1122_3344_5566_7788);
    end

    send(8'h47, 0);
    chk("go_enable", 64'(cpu_enable), 64'd1);
    send(8'h00, 0);
    chk("run_discard", 64'(cpu_enable), 64'd1);
    send(8'h48, 0);
    chk("halt_enable", 64'(cpu_enable), 64'd0);
    chk("halt_busy", 64'(busy), 64'd0);

    reset_pulse();
    bq = '{8'h49, 8'h81, 8'h00};
    send_bq(0); idle(2);
    chk("ovf_error", 64'(error), 64'd1);
    chk("ovf_ready", 64'(in_ready), 64'd0);
    chk("ovf_nowrite", 64'(cap_i.size()), 64'd0);
    reset_pulse();
    chk("ovf_rst_error", 64'(error), 64'd0);
    chk("ovf_rst_ready", 64'(in_ready), 64'd1);

    send(8'h55, 0); idle(1);
    chk("bad_cmd_error", 64'(error), 64'd1);
    reset_pulse();
    bq = '{8'h49, 8'h00, 8'h00};
    send_bq(0); idle(2);
    chk("n0_busy", 64'(busy), 64'd0);
    chk("n0_nowrite", 64'(cap_i.size()), 64'd0);

    // 3-word I load with random valid gaps, aborted by reset inside word 1
    bq = '{8'h49, 8'h03, 8'h00, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h11, 8'h22};
    send_bq(50);
    #2 arst = 1'b1;
    #1 chk("abort_ready", 64'(in_ready), 64'd1);
    chk("abort_addr", addr_ext, 64'd0);
    @(posedge clk); #1 arst = 1'b0;
    chk("abort_count", 64'(cap_i.size()), 64'd1);
    if (cap_i.size() == 1) chk("abort_word0", cap_i[0], {32'h0, 32'hD4C3_B2A1});
    cap_i.delete();

    // Reset landing inside the WRITE cycle drops the strobe at once
    bq = '{8'h44, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    send_bq(0);
    chk("mid_write_strobe", 64'(wen_ext_2), 64'd1);
    #1 arst = 1'b1;
    #1 chk("mid_write_drop", 64'(wen_ext_2), 64'd0);
    chk("mid_write_data", wdata_ext_2, 64'd0);
    @(posedge clk); #1 arst = 1'b0;
    cap_i.delete(); cap_da.delete(); cap_dd.delete();

    push_frame(8'h49, IW, 4);
    send_bq(0); idle(2);
    chk("full_i_count", 64'(cap_i.size()), 64'(IW));
    if (cap_i.size() == IW) chk("full_i_last_addr", 64'(cap_i[IW-1][63:32]), 64'h1FC);

    for (int it = 0; it < 30; it++) begin
      int r, g;
      logic [7:0] x;
      r = $urandom_range(9);
      g = $urandom_range(60);
      if (r <= 3) push_frame(8'h49, $urandom_range(4), 4);
      else if (r <= 6) push_frame(8'h44, $urandom_range(3), 8);
      else if (r == 7) begin
        bq.push_back(8'h47);
        repeat ($urandom_range(3)) begin
          x = 8'($urandom);
          if (x == 8'h48) x = 8'h00;
          bq.push_back(x);
        end
        bq.push_back(8'h48);
      end else if (r == 8) bq.push_back(8'h48);
      send_bq(g);
      idle($urandom_range(3));
    end

    push_frame(8'h44, DW + 1 + $urandom_range(100), 0);
    send_bq(20); idle(2);
    chk("ovf_d_error", 64'(error), 64'd1);
    reset_pulse();
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
